// File: rtl/video_pkg.sv
// Shared video constants: BT.601 full-range YCbCr->RGB coefficients (x256),
// pixel field positions and internal arithmetic widths.
// Latency: n/a (constants only). Backpressure: n/a.
package video_pkg;

   // Component and field layout of a packed 24-bit pixel
   localparam int COMP_W = 8;
   localparam int PIX_W  = 3 * COMP_W;
   localparam int Y_LSB  = 16;   // also R in the output word
   localparam int CB_LSB = 8;    // also G
   localparam int CR_LSB = 0;    // also B

   // Internal widths: Y<<8, signed chroma, signed accumulator
   localparam int YS_W  = 16;
   localparam int CHR_W = 9;
   localparam int ACC_W = 19;
   localparam int FRAC  = 8;

   // Coefficients scaled by 256
   localparam logic signed [ACC_W-1:0] C_RCR = 19'sd359;
   localparam logic signed [ACC_W-1:0] C_GCB = 19'sd88;
   localparam logic signed [ACC_W-1:0] C_GCR = 19'sd183;
   localparam logic signed [ACC_W-1:0] C_BCB = 19'sd454;

   localparam logic [CHR_W-1:0]        CHROMA_OFS = 9'd128;
   localparam logic signed [ACC_W-1:0] ROUND      = 19'sd128;

endpackage

// File: rtl/ycbcr2rgb_conv_sat_u8.sv
// sat_u8: rounds a signed x256 fixed-point value, drops the fraction and
// clamps to 0..255. Ports: acc (signed 19b in), q (8b out).
// Latency: combinational. Backpressure: n/a.
module sat_u8
   import video_pkg::*;
(
   input  logic signed [ACC_W-1:0]  acc,
   output logic        [COMP_W-1:0] q
);

   logic signed [ACC_W-1:0] rnd;
   logic signed [ACC_W-1:0] t;

   // Accumulator range is well inside 19 bits, so +ROUND cannot overflow
   assign rnd = acc + ROUND;
   assign t   = rnd >>> FRAC;

   always_comb begin
      q = t[COMP_W-1:0];
      if (t[ACC_W-1])
         q = '0;                    // negative -> black
      else if (|t[ACC_W-2:COMP_W])
         q = '1;                    // above 255 -> full scale
   end

endmodule

// File: rtl/ycbcr2rgb_conv.sv
// YCbCr 4:4:4 (BT.601 full range) to RGB888 converter with sideband passthrough.
// Ports: clk/rst_n; data_in/data_in_valid/data_in_ready/sb_in in;
//        data_out/data_out_valid/data_out_ready/sb_out out.
// Latency: 3 enabled cycles. Backpressure: global stall, every stage holds
// while the output is valid and not accepted; data_in_ready mirrors the enable.
module ycbcr2rgb_conv
   import video_pkg::*;
#(
   parameter int SB_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PIX_W-1:0]  data_in,
   input  logic              data_in_valid,
   output logic              data_in_ready,
   input  logic [SB_W-1:0]   sb_in,
   output logic [PIX_W-1:0]  data_out,
   output logic              data_out_valid,
   input  logic              data_out_ready,
   output logic [SB_W-1:0]   sb_out
);

   logic en;

   // Stage 1 registers
   logic                    v1;
   logic [YS_W-1:0]         ys1;
   logic signed [CHR_W-1:0] cbs1, crs1;
   logic [SB_W-1:0]         sb1;

   // Stage 2 registers
   logic                    v2;
   logic signed [ACC_W-1:0] r_acc, g_acc, b_acc;
   logic [SB_W-1:0]         sb2;

   // Stage 2 operands widened to accumulator width
   logic signed [ACC_W-1:0] ys_x, cbs_x, crs_x;
   logic [COMP_W-1:0]       r_q, g_q, b_q;

   // Whole pipeline advances unless a valid output is being refused
   assign en            = data_out_ready | ~data_out_valid;
   assign data_in_ready = en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1   <= 1'b0;
         ys1  <= '0;
         cbs1 <= '0;
         crs1 <= '0;
         sb1  <= '0;
      end else if (en) begin
         v1 <= data_in_valid;
         if (data_in_valid) begin
            ys1  <= {data_in[Y_LSB +: COMP_W], 8'd0};
            cbs1 <= $signed({1'b0, data_in[CB_LSB +: COMP_W]} - CHROMA_OFS);
            crs1 <= $signed({1'b0, data_in[CR_LSB +: COMP_W]} - CHROMA_OFS);
            sb1  <= sb_in;
         end
      end
   end

   assign ys_x  = $signed({3'b000, ys1});
   assign cbs_x = {{(ACC_W-CHR_W){cbs1[CHR_W-1]}}, cbs1};
   assign crs_x = {{(ACC_W-CHR_W){crs1[CHR_W-1]}}, crs1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2    <= 1'b0;
         r_acc <= '0;
         g_acc <= '0;
         b_acc <= '0;
         sb2   <= '0;
      end else if (en) begin
         v2 <= v1;
         if (v1) begin
            r_acc <= ys_x + C_RCR * crs_x;
            g_acc <= ys_x - C_GCB * cbs_x - C_GCR * crs_x;
            b_acc <= ys_x + C_BCB * cbs_x;
            sb2   <= sb1;
         end
      end
   end

   sat_u8 u_sat_r (.acc(r_acc), .q(r_q));
   sat_u8 u_sat_g (.acc(g_acc), .q(g_q));
   sat_u8 u_sat_b (.acc(b_acc), .q(b_q));

   // Output register: holds its value across stalls and bubbles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_valid <= 1'b0;
         data_out       <= '0;
         sb_out         <= '0;
      end else if (en) begin
         data_out_valid <= v2;
         if (v2) begin
            data_out <= {r_q, g_q, b_q};
            sb_out   <= sb2;
         end
      end
   end

endmodule
